// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake bundle for the pipelined immediate generator.
//   Upstream side : in_valid / in_ready, in_imm (instr[31:7]), in_src, in_tag
//   Downstream    : out_valid / out_ready, out_imm, out_illegal, out_tag
// Modports
//   master : the driver of instructions and consumer of results (bench/decoder)
//   slave  : the immediate generator itself
// Parameters must match the XLEN/TAG_W of the attached imm_gen_pipe.
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_imm;
    logic [2:0]       in_src;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined RISC-V immediate generator for the decode stage. The immediate is
// extracted and extended combinationally from instr[31:7] and registered into
// stage 0; it then walks STAGES register stages together with its illegal flag
// and sideband tag. Each stage has its own valid bit, so bubbles are squeezed
// out while the downstream consumer is stalled.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (clears valids and output data)
//   i_flush  synchronous flush: drops every in-flight entry and refuses input
//   io_bus   imm_gen_pipe_if.slave -- valid/ready in, valid/ready out
//
// Parameters
//   XLEN   32 or 64; sign extension always fills bit XLEN-1
//   STAGES 1..4; latency is STAGES cycles when unstalled
//   TAG_W  sideband width, passed through untouched
//
// Format select (in_src):
//   000 I, 001 S, 101 B, 010 J, 011 U, 100 shamt, 110/111 reserved
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    imm_gen_pipe_if.slave io_bus
);

    localparam logic [2:0] SRC_I  = 3'b000;
    localparam logic [2:0] SRC_S  = 3'b001;
    localparam logic [2:0] SRC_J  = 3'b010;
    localparam logic [2:0] SRC_U  = 3'b011;
    localparam logic [2:0] SRC_SH = 3'b100;
    localparam logic [2:0] SRC_B  = 3'b101;

    // -----------------------------------------------------------------------
    // Extension. in_imm[k] holds instr[k+7], so instr[n] is in_imm[n-7].
    // Every signed format is first assembled as a 32-bit two's-complement
    // value and then sign-cast to XLEN; for XLEN=64 that copies instr[31]
    // into bits 63:32, which is exactly the RV64 rule for U as well.
    // -----------------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;

    always_comb begin
        w_imm32 = '0;
        w_ill   = 1'b0;
        // RV64 shifts use a 6-bit shamt (instr[25:20]); RV32 only 5 bits.
        w_shamt = (XLEN == 64) ? io_bus.in_imm[18:13]
                               : {1'b0, io_bus.in_imm[17:13]};
        unique case (io_bus.in_src)
            SRC_I:  w_imm32 = {{20{io_bus.in_imm[24]}}, io_bus.in_imm[24:13]};
            SRC_S:  w_imm32 = {{20{io_bus.in_imm[24]}}, io_bus.in_imm[24:18],
                               io_bus.in_imm[4:0]};
            SRC_B:  w_imm32 = {{20{io_bus.in_imm[24]}}, io_bus.in_imm[0],
                               io_bus.in_imm[23:18], io_bus.in_imm[4:1], 1'b0};
            SRC_J:  w_imm32 = {{12{io_bus.in_imm[24]}}, io_bus.in_imm[12:5],
                               io_bus.in_imm[13], io_bus.in_imm[23:14], 1'b0};
            SRC_U:  w_imm32 = {io_bus.in_imm[24:5], 12'b0};
            SRC_SH: w_imm32 = '0;
            default: w_ill  = 1'b1;   // 110/111: reserved, immediate forced to 0
        endcase
        w_imm = XLEN'($signed(w_imm32));
        if (io_bus.in_src == SRC_SH) begin
            w_imm = XLEN'(w_shamt);   // shift amounts are never sign-extended
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline registers
    // -----------------------------------------------------------------------
    logic [STAGES-1:0]            r_vld_pipe;
    logic [STAGES-1:0][XLEN-1:0]  r_imm;
    logic [STAGES-1:0]            r_ill;
    logic [STAGES-1:0][TAG_W-1:0] r_tag;

    // w_open[k]: stage k may load this cycle, i.e. it is empty or its current
    // content moves on. Walking from the output backwards, a stage opens when
    // it is empty or everything in front of it can move; this is what lets a
    // stalled pipe still close up bubbles.
    logic [STAGES-1:0] w_open;

    always_comb begin : open_chain
        logic w_nxt;
        w_nxt  = io_bus.out_ready;
        w_open = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_nxt     = !r_vld_pipe[k] || w_nxt;
            w_open[k] = w_nxt;
        end
    end

    logic w_acc;
    assign io_bus.in_ready = !i_flush && w_open[0];
    assign w_acc           = io_bus.in_valid && io_bus.in_ready;

    // What each stage would load: the freshly extended immediate for stage 0,
    // the previous stage's registers otherwise.
    logic [STAGES-1:0]            w_src_vld;
    logic [STAGES-1:0][XLEN-1:0]  w_src_imm;
    logic [STAGES-1:0]            w_src_ill;
    logic [STAGES-1:0][TAG_W-1:0] w_src_tag;

    always_comb begin
        w_src_vld    = '0;
        w_src_imm    = '0;
        w_src_ill    = '0;
        w_src_tag    = '0;
        w_src_vld[0] = w_acc;
        w_src_imm[0] = w_imm;
        w_src_ill[0] = w_ill;
        w_src_tag[0] = io_bus.in_tag;
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld_pipe[k-1];
            w_src_imm[k] = r_imm[k-1];
            w_src_ill[k] = r_ill[k-1];
            w_src_tag[k] = r_tag[k-1];
        end
    end

    // Flush only clears valids; data registers may hold stale values since
    // nothing downstream looks at them without a valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_pipe <= '0;
            r_imm      <= '0;
            r_ill      <= '0;
            r_tag      <= '0;
        end else if (i_flush) begin
            r_vld_pipe <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_open[k]) begin
                    r_vld_pipe[k] <= w_src_vld[k];
                    // Data only moves with a valid, so a stalled output stays
                    // stable and an empty slot keeps its last contents.
                    if (w_src_vld[k]) begin
                        r_imm[k] <= w_src_imm[k];
                        r_ill[k] <= w_src_ill[k];
                        r_tag[k] <= w_src_tag[k];
                    end
                end
            end
        end
    end

    assign io_bus.out_valid   = r_vld_pipe[STAGES-1];
    assign io_bus.out_imm     = r_imm[STAGES-1];
    assign io_bus.out_illegal = r_ill[STAGES-1];
    assign io_bus.out_tag     = r_tag[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
// Two instances: u32 (XLEN=32, STAGES=2) and u64 (XLEN=64, STAGES=1).
// The 32-bit instance is watched every cycle by a queue-based model that
// predicts out_valid, in_ready and the result payload from arithmetic
// immediate rules; directed sequences and random traffic run underneath it.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  src;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic        ill;
        logic [31:0] tag;
        int          stamp;
    } ent_t;

    logic clk = 1'b0;
    logic rst32_n, rst64_n, flush32, flush64;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    ent_t q[$];
    logic [31:0] got[$];
    vec_t t32[10];
    vec_t t64[5];
    vec_t rv;
    logic acc;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) a ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b ();

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(32)) u32 (
        .i_clk(clk), .i_rst_n(rst32_n), .i_flush(flush32), .io_bus(a)
    );
    imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(32)) u64 (
        .i_clk(clk), .i_rst_n(rst64_n), .i_flush(flush64), .io_bus(b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Immediate value computed numerically from the ISA field definitions.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] src,
                                            input bit x64);
        longint v;
        case (src)
            3'b000: v = $signed(i[31:20]);
            3'b001: begin v = $signed(i[31:25]); v = v * 32 + longint'(i[11:7]); end
            3'b101: v = (i[31] ? -4096 : 0) + longint'(i[7]) * 2048
                        + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            3'b010: v = (i[31] ? -1048576 : 0) + longint'(i[19:12]) * 4096
                        + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            3'b011: begin v = $signed(i[31:12]); v = v * 4096; end
            3'b100: v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
            default: v = 0;
        endcase
        return x64 ? 64'(v) : {32'b0, v[31:0]};
    endfunction

    // Cycle-level model of u32: an entry accepted at cycle n is visible from
    // cycle n+STAGES until consumed; stage 0 opens whenever the pipe is not
    // full or downstream is ready.
    always @(negedge clk) begin : mon
        logic ev, er;
        ent_t e;
        cyc++;
        if (!rst32_n) begin
            q.delete();
            chk("rst_out_valid32", 64'(a.out_valid), 64'd0);
        end else begin
            ev = (q.size() > 0) && (cyc - q[0].stamp >= 2);
            er = !flush32 && (a.out_ready || q.size() < 2);
            chk("mon_out_valid", 64'(a.out_valid), 64'(ev));
            chk("mon_in_ready", 64'(a.in_ready), 64'(er));
            if (ev) begin
                chk("mon_out_imm", 64'(a.out_imm), 64'(q[0].imm));
                chk("mon_out_illegal", 64'(a.out_illegal), 64'(q[0].ill));
                chk("mon_out_tag", 64'(a.out_tag), 64'(q[0].tag));
            end
            if (flush32) begin
                q.delete();
            end else begin
                if (ev && a.out_ready) void'(q.pop_front());
                if (a.in_valid && er) begin
                    e.imm   = 32'(ref_imm({a.in_imm, 7'b0}, a.in_src, 1'b0));
                    e.ill   = a.in_src[2] && a.in_src[1];
                    e.tag   = a.in_tag;
                    e.stamp = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic drive32(input vec_t v, input logic [31:0] tag);
        a.in_imm = v.ins[31:7];
        a.in_src = v.src;
        a.in_tag = tag;
    endtask

    task automatic vec32(input vec_t v, input logic [31:0] tag);
        int lat;
        drive32(v, tag);
        a.in_valid  = 1'b1;
        a.out_ready = 1'b1;
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        lat = 1;
        while (!a.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat32", 64'(lat), 64'd2);
        chk("imm32", 64'(a.out_imm), {32'b0, v.exp[31:0]});
        chk("ill32", 64'(a.out_illegal), 64'(v.ill));
        chk("tag32", 64'(a.out_tag), 64'(tag));
        @(posedge clk); #1;
    endtask

    task automatic vec64(input vec_t v, input logic [31:0] tag);
        int lat;
        b.in_imm    = v.ins[31:7];
        b.in_src    = v.src;
        b.in_tag    = tag;
        b.in_valid  = 1'b1;
        b.out_ready = 1'b1;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        lat = 1;
        while (!b.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat64", 64'(lat), 64'd1);
        chk("imm64", b.out_imm, v.exp);
        chk("ill64", 64'(b.out_illegal), 64'(v.ill));
        chk("tag64", 64'(b.out_tag), 64'(tag));
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        t32[0] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 1'b0};
        t32[1] = '{32'hFE20AE23, 3'b001, 64'hFFFFFFFC, 1'b0};
        t32[2] = '{32'hFE000CE3, 3'b101, 64'hFFFFFFF8, 1'b0};
        t32[3] = '{32'hFFDFF06F, 3'b010, 64'hFFFFFFFC, 1'b0};
        t32[4] = '{32'h123452B7, 3'b011, 64'h12345000, 1'b0};
        t32[5] = '{32'hFFF00093, 3'b110, 64'h0, 1'b1};
        t32[6] = '{32'hFFF00093, 3'b111, 64'h0, 1'b1};
        t32[7] = '{32'h43F0D093, 3'b100, 64'h1F, 1'b0};
        t32[8] = '{32'h7FF00093, 3'b000, 64'h7FF, 1'b0};
        t32[9] = '{32'h00A12423, 3'b001, 64'h8, 1'b0};
        t64[0] = '{32'h43F0D093, 3'b100, 64'h000000000000003F, 1'b0};
        t64[1] = '{32'h800002B7, 3'b011, 64'hFFFFFFFF80000000, 1'b0};
        t64[2] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        t64[3] = '{32'h123452B7, 3'b011, 64'h0000000012345000, 1'b0};
        t64[4] = '{32'hFE000CE3, 3'b111, 64'h0, 1'b1};

        rst32_n = 1'b0; rst64_n = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
        a.in_valid = 1'b0; a.in_imm = '0; a.in_src = '0; a.in_tag = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_imm = '0; b.in_src = '0; b.in_tag = '0; b.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid32", 64'(a.out_valid), 64'd0);
        chk("rst_imm32", 64'(a.out_imm), 64'd0);
        chk("rst_tag32", 64'(a.out_tag), 64'd0);
        chk("rst_ill32", 64'(a.out_illegal), 64'd0);
        chk("rst_valid64", 64'(b.out_valid), 64'd0);
        chk("rst_imm64", b.out_imm, 64'd0);
        rst32_n = 1'b1; rst64_n = 1'b1;
        @(posedge clk); #1;

        // Single-shot table on the 32-bit, 2-stage instance
        for (int i = 0; i < 10; i++) vec32(t32[i], 32'(i + 1));

        // Back-to-back stream with out_ready held high
        a.out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                drive32(t32[1 + c], 32'(100 + c));
                a.in_valid = 1'b1;
            end else begin
                a.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("b2b_valid", 64'(a.out_valid), 64'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) begin
                chk("b2b_tag", 64'(a.out_tag), 64'(100 + c - 1));
                chk("b2b_imm", 64'(a.out_imm), t32[c].exp);
            end
        end

        // Stall: three offered, two accepted, output frozen, then drained
        a.out_ready = 1'b0;
        drive32(t32[0], 32'd200); a.in_valid = 1'b1;
        @(posedge clk); #1;
        drive32(t32[4], 32'd201);
        @(posedge clk); #1;
        drive32(t32[2], 32'd202);
        #1;
        chk("hold_in_ready", 64'(a.in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(a.out_valid), 64'd1);
            chk("hold_tag", 64'(a.out_tag), 64'd200);
            chk("hold_imm", 64'(a.out_imm), 64'hFFFFFFFF);
        end
        a.out_ready = 1'b1;
        got.delete();
        #1;
        for (int c = 0; c < 10; c++) begin
            acc = a.in_valid && a.in_ready;
            if (a.out_valid) got.push_back(a.out_tag);
            @(posedge clk); #1;
            if (acc) a.in_valid = 1'b0;
        end
        chk("drain_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk("drain_order", 64'(got[i]), 64'(200 + i));

        // Flush with two in flight and a new instruction offered
        a.out_ready = 1'b0;
        drive32(t32[1], 32'd300); a.in_valid = 1'b1;
        @(posedge clk); #1;
        drive32(t32[2], 32'd301);
        @(posedge clk); #1;
        drive32(t32[3], 32'd302);
        flush32 = 1'b1;
        #1;
        chk("flush_in_ready", 64'(a.in_ready), 64'd0);
        @(posedge clk); #1;
        flush32 = 1'b0; a.in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(a.out_valid), 64'd0);
        chk("flush_in_ready_after", 64'(a.in_ready), 64'd1);
        a.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("flush_no_emit", 64'(a.out_valid), 64'd0);
        end

        // Random traffic on the 32-bit instance, checked by the monitor
        for (int c = 0; c < 1500; c++) begin
            a.in_valid  = ($urandom_range(0, 3) != 0);
            a.in_imm    = 25'($urandom);
            a.in_src    = 3'($urandom_range(0, 7));
            a.in_tag    = $urandom;
            a.out_ready = ($urandom_range(0, 3) != 0);
            flush32     = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        a.in_valid = 1'b0; flush32 = 1'b0; a.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 64-bit, 1-stage instance: table then random single shots
        for (int i = 0; i < 5; i++) vec64(t64[i], 32'(500 + i));
        for (int i = 0; i < 40; i++) begin
            rv.ins = $urandom;
            rv.src = 3'($urandom_range(0, 7));
            rv.exp = ref_imm(rv.ins, rv.src, 1'b1);
            rv.ill = rv.src[2] && rv.src[1];
            vec64(rv, 32'(600 + i));
        end

        // Asynchronous reset in the middle of a stalled stream
        b.out_ready = 1'b0;
        b.in_imm = t64[1].ins[31:7]; b.in_src = t64[1].src; b.in_tag = 32'h55;
        b.in_valid = 1'b1;
        @(posedge clk); #1;
        b.in_tag = 32'h56;
        chk("mid_pre_valid", 64'(b.out_valid), 64'd1);
        chk("mid_pre_imm", b.out_imm, 64'hFFFFFFFF80000000);
        #2 rst64_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(b.out_valid), 64'd0);
        chk("mid_rst_imm", b.out_imm, 64'd0);
        chk("mid_rst_ill", 64'(b.out_illegal), 64'd0);
        chk("mid_rst_tag", 64'(b.out_tag), 64'd0);
        b.in_valid = 1'b0;
        @(posedge clk); #3;
        rst64_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(b.out_valid), 64'd0);
        vec64(t64[0], 32'h57);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
